// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the EX-stage multiplier issue/collect controller.
// Op encoding is one-hot; a tag travels with each in-flight multiply.
package mul_issue_ctrl_pkg;

  localparam int MUL_OP_W   = 3;
  localparam int MUL_W      = 0;
  localparam int MULH_W     = 1;
  localparam int MULH_WU    = 2;
  localparam int MUL_DEST_W = 5;

  typedef struct packed {
    logic                  hi_sel;
    logic [MUL_DEST_W-1:0] dest;
    logic                  kill;
  } mul_tag_t;

  // mulh.w and mulh.wu both return the upper product half.
  function automatic logic op_is_high(input logic [MUL_OP_W-1:0] op);
    return op[MULH_W] | op[MULH_WU];
  endfunction

endpackage

// File: rtl/mul_tag_fifo.sv
// In-order tag FIFO for ops issued to the multiplier but not yet answered.
// kill_all marks every stored tag so its response is dropped on pop.
module mul_tag_fifo
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  mul_tag_t push_tag,
  input  logic     pop,
  input  logic     kill_all,
  output mul_tag_t head_tag,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  mul_tag_t         mem_q [DEPTH];
  mul_tag_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Marking empty slots too is harmless: every push rewrites kill to 0.
    if (kill_all) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i].kill = 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_tag = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues multiply micro-ops to the pipelined multiplier, collects responses
// in order, selects the requested product half and holds it for WB.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DEST_W = MUL_DEST_W
) (
  input  logic                mul_clk,
  input  logic                resetn,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [MUL_OP_W-1:0] ex_mul_op,
  input  logic [31:0]         ex_src1,
  input  logic [31:0]         ex_src2,
  input  logic [DEST_W-1:0]   ex_dest,
  input  logic                flush,
  output logic                to_mul_req_valid,
  input  logic                from_mul_req_ready,
  output logic [MUL_OP_W-1:0] mul_op,
  output logic [31:0]         mul_x,
  output logic [31:0]         mul_y,
  input  logic                from_mul_resp_valid,
  output logic                to_mul_resp_ready,
  input  logic [63:0]         mul_result,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [DEST_W-1:0]   wb_dest,
  output logic [31:0]         wb_data
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and ex_ready never looks at WB.
  mul_tag_t    push_tag, head_tag;
  logic        fifo_full, fifo_empty;
  logic        req_fire, resp_fire, wb_load;
  logic        wb_valid_q, wb_valid_d;
  logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;

  assign to_mul_req_valid = ex_valid & ~flush & ~fifo_full;
  assign ex_ready         = from_mul_req_ready & ~flush & ~fifo_full;
  assign req_fire         = to_mul_req_valid & from_mul_req_ready;
  assign mul_op           = ex_mul_op;
  assign mul_x            = ex_src1;
  assign mul_y            = ex_src2;

  assign push_tag = '{hi_sel: op_is_high(ex_mul_op), dest: ex_dest, kill: 1'b0};

  // Killed or flushed responses are drained regardless of WB backpressure.
  assign to_mul_resp_ready = ~fifo_empty &
                             (head_tag.kill | flush | ~wb_valid_q | wb_ready);
  assign resp_fire = from_mul_resp_valid & to_mul_resp_ready;
  assign wb_load   = resp_fire & ~head_tag.kill & ~flush;

  mul_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk      (mul_clk),
    .resetn   (resetn),
    .push     (req_fire),
    .push_tag (push_tag),
    .pop      (resp_fire),
    .kill_all (flush),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    if (wb_valid_q & wb_ready) wb_valid_d = 1'b0;
    if (flush) wb_valid_d = 1'b0;
    if (wb_load) begin
      wb_valid_d = 1'b1;
      wb_dest_d  = head_tag.dest;
      wb_data_d  = head_tag.hi_sel ? mul_result[63:32] : mul_result[31:0];
    end
  end

  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_dest  = wb_dest_q;
  assign wb_data  = wb_data_q;

  // A response with nothing outstanding means the multiplier lost sync.
  a_no_orphan_resp: assert property (@(posedge mul_clk) disable iff (!resetn)
    !(from_mul_resp_valid && fifo_empty));

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Cycle-accurate directed bench for mul_issue_ctrl with a small multiplier
// model answering one cycle after each accepted request.
module tb_mul_issue_ctrl;

  localparam logic [2:0] OP_N  = 3'b000;
  localparam logic [2:0] OP_W  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_HU = 3'b100;

  logic        mul_clk, resetn;
  logic        ex_valid, ex_ready;
  logic [2:0]  ex_mul_op;
  logic [31:0] ex_src1, ex_src2;
  logic [4:0]  ex_dest;
  logic        flush;
  logic        to_mul_req_valid, from_mul_req_ready;
  logic [2:0]  mul_op;
  logic [31:0] mul_x, mul_y;
  logic        from_mul_resp_valid, to_mul_resp_ready;
  logic [63:0] mul_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  mul_issue_ctrl #(.DEPTH(2), .DEST_W(5)) dut (
    .mul_clk(mul_clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mul_op(ex_mul_op),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest), .flush(flush),
    .to_mul_req_valid(to_mul_req_valid), .from_mul_req_ready(from_mul_req_ready),
    .mul_op(mul_op), .mul_x(mul_x), .mul_y(mul_y),
    .from_mul_resp_valid(from_mul_resp_valid), .to_mul_resp_ready(to_mul_resp_ready),
    .mul_result(mul_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  // clock / reset
  initial begin
    mul_clk = 1'b0;
    forever #5 mul_clk = ~mul_clk;
  end

  // multiplier model: samples late in the cycle, answers after the edge
  logic [63:0] resp_q[$];

  function automatic logic [63:0] mul_model(input logic [2:0] op, input logic [31:0] x, y);
    if (op == OP_HU) return {32'b0, x} * {32'b0, y};
    return {{32{x[31]}}, x} * {{32{y[31]}}, y};
  endfunction

  initial begin
    logic        s_rst, s_req, s_resp;
    logic [63:0] s_prod;
    from_mul_resp_valid = 1'b0;
    mul_result          = '0;
    forever begin
      @(negedge mul_clk);
      #4;
      s_rst  = !resetn;
      s_req  = to_mul_req_valid && from_mul_req_ready;
      s_resp = from_mul_resp_valid && to_mul_resp_ready;
      s_prod = mul_model(mul_op, mul_x, mul_y);
      @(posedge mul_clk);
      #1;
      if (s_rst) resp_q.delete();
      else begin
        if (s_resp) void'(resp_q.pop_front());
        if (s_req) resp_q.push_back(s_prod);
      end
      from_mul_resp_valid = (resp_q.size() > 0);
      mul_result          = (resp_q.size() > 0) ? resp_q[0] : 64'd0;
    end
  end

  // driver and checker
  typedef struct {
    logic        ev;
    logic [2:0]  op;
    logic [31:0] x, y;
    logic [4:0]  dest;
    logic        fl, wr;
    logic        exp_rdy, exp_wbv;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic ev, input logic [2:0] op, input logic [31:0] x, y,
                     input logic [4:0] dest, input logic fl, wr,
                     input logic exp_rdy, exp_wbv, input logic [4:0] exp_dest,
                     input logic [31:0] exp_data);
    vec_t v;
    v.ev = ev; v.op = op; v.x = x; v.y = y; v.dest = dest; v.fl = fl; v.wr = wr;
    v.exp_rdy = exp_rdy; v.exp_wbv = exp_wbv; v.exp_dest = exp_dest; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic fl, wr, input logic exp_rdy, exp_wbv,
                      input logic [4:0] exp_dest, input logic [31:0] exp_data);
    add(1'b0, OP_N, 32'd0, 32'd0, 5'd0, fl, wr, exp_rdy, exp_wbv, exp_dest, exp_data);
  endtask

  task automatic drive(input logic ev, input logic [2:0] op, input logic [31:0] x, y,
                       input logic [4:0] dest, input logic fl, wr);
    ex_valid = ev; ex_mul_op = op; ex_src1 = x; ex_src2 = y;
    ex_dest = dest; flush = fl; wb_ready = wr;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // mul.w basic latency
    add(1, OP_W, 32'hFFFFFFFF, 32'd2, 5'd3, 0, 1,  1, 0, 5'd0, 32'h0);
    idle(0, 1,  1, 0, 5'd0, 32'h0);
    idle(0, 1,  1, 1, 5'd3, 32'hFFFFFFFE);
    idle(0, 1,  1, 0, 5'd3, 32'hFFFFFFFE);
    // back-to-back high halves
    add(1, OP_H,  32'h80000000, 32'h80000000, 5'd4, 0, 1,  1, 0, 5'd3, 32'hFFFFFFFE);
    add(1, OP_HU, 32'h80000000, 32'h80000000, 5'd5, 0, 1,  1, 0, 5'd3, 32'hFFFFFFFE);
    add(1, OP_H,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0, 1,  1, 1, 5'd4, 32'h40000000);
    add(1, OP_HU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 0, 1,  1, 1, 5'd5, 32'h40000000);
    idle(0, 1,  1, 1, 5'd6, 32'h00000000);
    idle(0, 1,  1, 1, 5'd7, 32'hFFFFFFFE);
    idle(0, 1,  1, 0, 5'd7, 32'hFFFFFFFE);
    // WB backpressure fills the FIFO, then drains in order
    add(1, OP_W, 32'd3,   32'd5,   5'd8,  0, 0,  1, 0, 5'd7, 32'hFFFFFFFE);
    add(1, OP_W, 32'd7,   32'd6,   5'd9,  0, 0,  1, 0, 5'd7, 32'hFFFFFFFE);
    add(1, OP_W, 32'd100, 32'd100, 5'd10, 0, 0,  1, 1, 5'd8, 32'h0000000F);
    add(1, OP_W, 32'd2,   32'd9,   5'd11, 0, 0,  0, 1, 5'd8, 32'h0000000F);
    add(1, OP_W, 32'd2,   32'd9,   5'd11, 0, 0,  0, 1, 5'd8, 32'h0000000F);
    add(1, OP_W, 32'd2,   32'd9,   5'd11, 0, 1,  0, 1, 5'd8, 32'h0000000F);
    add(1, OP_W, 32'd2,   32'd9,   5'd11, 0, 1,  1, 1, 5'd9, 32'h0000002A);
    idle(0, 1,  1, 1, 5'd10, 32'h00002710);
    idle(0, 1,  1, 1, 5'd11, 32'h00000012);
    idle(0, 1,  1, 0, 5'd11, 32'h00000012);
    // flush with two in flight and a parked result
    add(1, OP_W, 32'd1, 32'd11, 5'd12, 0, 0,  1, 0, 5'd11, 32'h00000012);
    add(1, OP_W, 32'd1, 32'd12, 5'd13, 0, 0,  1, 0, 5'd11, 32'h00000012);
    add(1, OP_W, 32'd1, 32'd13, 5'd14, 0, 0,  1, 1, 5'd12, 32'h0000000B);
    idle(1, 0,  0, 1, 5'd12, 32'h0000000B);
    idle(0, 0,  1, 0, 5'd12, 32'h0000000B);
    idle(0, 0,  1, 0, 5'd12, 32'h0000000B);
    add(1, OP_HU, 32'hFFFFFFFF, 32'd2, 5'd15, 0, 1,  1, 0, 5'd12, 32'h0000000B);
    idle(0, 1,  1, 0, 5'd12, 32'h0000000B);
    idle(0, 1,  1, 1, 5'd15, 32'h00000001);
    idle(0, 1,  1, 0, 5'd15, 32'h00000001);
    // flush coincident with an offered op and a response
    add(1, OP_W, 32'd2, 32'd3, 5'd16, 0, 1,  1, 0, 5'd15, 32'h00000001);
    add(1, OP_W, 32'd4, 32'd4, 5'd17, 1, 1,  0, 0, 5'd15, 32'h00000001);
    add(1, OP_W, 32'd5, 32'd5, 5'd18, 0, 1,  1, 0, 5'd15, 32'h00000001);
    add(1, OP_W, 32'd6, 32'd6, 5'd19, 0, 1,  1, 0, 5'd15, 32'h00000001);
    idle(0, 1,  1, 1, 5'd18, 32'h00000019);
    idle(0, 1,  1, 1, 5'd19, 32'h00000024);
    idle(0, 1,  1, 0, 5'd19, 32'h00000024);

    drive(0, OP_N, 0, 0, 0, 0, 1);
    from_mul_req_ready = 1'b1;
    resetn = 1'b0;
    repeat (2) @(posedge mul_clk);
    @(negedge mul_clk);
    #1;
    check("reset wb_valid", wb_valid, 0);
    check("reset wb_dest", wb_dest, 0);
    check("reset wb_data", wb_data, 0);
    check("reset ex_ready", ex_ready, 1);
    check("reset resp_ready", to_mul_resp_ready, 0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge mul_clk);
      drive(vecs[i].ev, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].dest, vecs[i].fl, vecs[i].wr);
      #1;
      check($sformatf("row%0d ex_ready", i), ex_ready, vecs[i].exp_rdy);
      check($sformatf("row%0d req_valid", i), to_mul_req_valid, vecs[i].ev & vecs[i].exp_rdy);
      check($sformatf("row%0d wb_valid", i), wb_valid, vecs[i].exp_wbv);
      check($sformatf("row%0d wb_dest", i), wb_dest, vecs[i].exp_dest);
      check($sformatf("row%0d wb_data", i), wb_data, vecs[i].exp_data);
    end

    // reset mid-stream with a parked result and a pending response
    @(negedge mul_clk);
    drive(1, OP_W, 32'd9, 32'd9, 5'd20, 0, 0);
    #1 check("mid ex_ready p", ex_ready, 1);
    @(negedge mul_clk);
    drive(1, OP_W, 32'd10, 32'd10, 5'd21, 0, 0);
    @(negedge mul_clk);
    drive(0, OP_N, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    #1;
    check("mid pre-reset wb_valid", wb_valid, 1);
    check("mid pre-reset wb_dest", wb_dest, 20);
    check("mid pre-reset wb_data", wb_data, 32'h51);
    @(negedge mul_clk);
    resetn = 1'b1;
    #1;
    check("post-reset wb_valid", wb_valid, 0);
    check("post-reset wb_dest", wb_dest, 0);
    check("post-reset wb_data", wb_data, 0);
    check("post-reset ex_ready", ex_ready, 1);
    check("post-reset resp_ready", to_mul_resp_ready, 0);
    drive(1, OP_W, 32'd1, 32'd1, 5'd1, 0, 1);
    from_mul_req_ready = 1'b0;
    #1;
    check("req_ready low ex_ready", ex_ready, 0);
    check("req_ready low req_valid", to_mul_req_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge mul_clk);
      from_mul_req_ready = 1'b1;
      drive(0, OP_N, 0, 0, 0, 0, 1);
      #1;
      check($sformatf("post-reset%0d wb_valid", k), wb_valid, 0);
      check($sformatf("post-reset%0d ex_ready", k), ex_ready, 1);
      check($sformatf("post-reset%0d resp_ready", k), to_mul_resp_ready, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
